// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the divide-by-zero quotient value.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  always_comb begin
    partial  = {rem, in_bit};
    diff     = partial - {1'b0, divisor};
    // rem < divisor keeps partial below 2*divisor, so diff's top bit is the borrow
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO. Define MDU_EARLY_TERM_EN to
// let multiplies leave CALC as soon as the remaining multiplier bits are zero.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   div_rem, quo_res, rem_res;
  logic               div_qbit;
`ifdef MDU_EARLY_TERM_EN
  logic [CNT_W-1:0]   left_q;
  logic               mul_early;
`endif

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Shift-add step: low half holds the unprocessed multiplier bits.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (prod_q[2*WIDTH-1:WIDTH]),
    .in_bit   (prod_q[WIDTH-1]),
    .divisor  (opnd_q),
    .rem_next (div_rem),
    .q_bit    (div_qbit)
  );
  assign div_next = {div_rem, prod_q[WIDTH-2:0], div_qbit};

`ifdef MDU_EARLY_TERM_EN
  assign left_q    = CNT_W'(WIDTH - 1) - cnt_q;
  assign mul_early = (mul_next[WIDTH-1:0] & ~({WIDTH{1'b1}} << left_q)) == '0;
`endif

  // With a zero divisor every step subtracts nothing, so the remainder half ends
  // up holding |a| and the remainder sign rule restores the raw dividend.
  assign prod_neg = -prod_q;
  assign quo_res  = dz_q ? WIDTH'(MDU_DIV0_LO) :
                    (neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0]);
  assign rem_res  = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end else if (!op[2]) begin
            is_div_d = op[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = (b == '0);
            opnd_d   = op[1] ? b_mag : a_mag;
            prod_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt_d    = '0;
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          prod_d = is_div_q ? div_next : mul_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StFix;
`ifdef MDU_EARLY_TERM_EN
          end else if (!is_div_q && mul_early) begin
            prod_d  = mul_next >> left_q;
            state_d = StFix;
`endif
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the EXE stage of the pipelined MIPS core.
- Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Owns the architectural HI/LO registers.
- Raises busy so the hazard logic stalls MFHI/MFLO and further mul/div issue.
- Aborts cleanly on an exception/interrupt flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe, one cycle, valid with op/a/b.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  cancel in-flight operation (exception/eret).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are committed by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators cleared. rst has priority over every other input.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start with MTHI: hi<=a next edge; busy stays 0; done stays 0.
  - start with MTLO: lo<=a next edge; busy stays 0; done stays 0.
  - start with mul/div: latch |a|, |b| (two's-complement magnitude for signed ops, raw for unsigned); latch the result sign flags and op; counter<=0; go to CALC.
  - Undefined op: ignored.
- CALC:
  - Exactly WIDTH iterations, one per cycle; counter increments 0..WIDTH-1; at WIDTH-1 go to FIX.
  - Multiply: radix-2 shift-add on a 2*WIDTH product register.
  - Divide: restoring, one quotient bit per cycle; 33-bit trial subtract.
- FIX:
  - Apply sign: product negated if sign(a)^sign(b) for MULT.
  - Quotient negated if sign(a)^sign(b); remainder takes the sign of a (DIV).
  - Commit hi/lo at the edge leaving FIX; done=1 for that following cycle; state=IDLE.
- busy=1 in CALC and FIX and on the cycle start is accepted is registered. Latency: start at cycle 0, busy 1..33, hi/lo valid and done=1 at cycle 34.
- Result mapping:
  - Mul: hi=product[63:32], lo=product[31:0].
  - Div: lo=quotient, hi=remainder.
- Divide by zero: no exception; result is lo=32'hFFFF_FFFF, hi=a (raw a, unsigned and signed alike); same latency.
- Signed edge cases:
  - DIV 0x8000_0000 / -1 gives lo=0x8000_0000, hi=0.
  - MULT 0x8000_0000 * 0x8000_0000 gives hi=0x4000_0000, lo=0.
- start while busy=1: ignored (the stall logic must not issue it; no queuing).
- flush (not rst):
  - Forces IDLE next edge; busy=0, done=0, hi/lo unchanged.
  - flush and start in the same IDLE cycle: start dropped, including MTHI/MTLO.
  - flush on the FIX cycle: commit suppressed.
- Mid-operation rst: as reset, hi/lo cleared.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: in CALC, a multiply whose remaining unprocessed multiplier bits are all zero exits to FIX immediately, with the product aligned by the remaining shift count. Example: MULTU by 1 gives busy for 2 cycles, done at cycle 3. Divide is unaffected.
- Undefined: fixed WIDTH-cycle latency for all mul/div.

Decomposition:
- Shared package mdu_pkg holds:
  - The op encoding constants MDU_MULT..MDU_MTLO.
  - The state typedef (IDLE/CALC/FIX).
  - The div-by-zero result constant.
- One sub-module, mdu_div_step: combinational single restoring-division step (partial remainder, divisor in; next remainder, quotient bit out), reused by CALC.
- Multiply shift-add stays inline.

Test Plan:
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> busy 33 cycles, done at cycle 34, hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT a=-7 (0xFFFF_FFF9), b=3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFF_FFFF, hi=100, latency unchanged.
- MTHI a=0x1234 then, next cycle, MTLO a=0x5678 -> hi=0x1234, lo=0x5678, busy never high.
- MULT issued, flush at cycle 10 (and separately at the FIX cycle) -> busy drops next edge, done never pulses, hi/lo keep prior values. rst mid-CALC -> hi=lo=0.
